// File: rtl/eth_tx_pkt_arbiter.sv
// Packet-granular two-port AXI-Stream arbiter feeding the Ethernet egress path through one register stage.
// Optional per-port packet counters are compiled in with ETH_TX_ARB_STATS_EN.
//   state | meaning
//   IDLE  | no owner, arbitrate among requesting ports
//   G0    | port 0 (CHDR) owns the egress until its tlast is accepted
//   G1    | port 1 (CPU) owns the egress until its tlast is accepted
module eth_tx_pkt_arbiter #(
  parameter int WIDTH       = 64,
  parameter int USER_WIDTH  = 4,
  parameter int STRICT_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [WIDTH-1:0]      s0_tdata,
  input  logic [USER_WIDTH-1:0] s0_tuser,
  input  logic                  s0_tlast,
  input  logic                  s0_tvalid,
  output logic                  s0_tready,
  input  logic [WIDTH-1:0]      s1_tdata,
  input  logic [USER_WIDTH-1:0] s1_tuser,
  input  logic                  s1_tlast,
  input  logic                  s1_tvalid,
  output logic                  s1_tready,
  output logic [WIDTH-1:0]      m_tdata,
  output logic [USER_WIDTH-1:0] m_tuser,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
`ifdef ETH_TX_ARB_STATS_EN
  input  logic                  clr_stats,
  output logic [31:0]           pkt_cnt0,
  output logic [31:0]           pkt_cnt1,
`endif
  output logic [1:0]            grant
);

  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  state_t state, state_nxt;
  logic   last_served, last_served_nxt;
  logic   out_ready;
  logic   acc0, acc1;

  assign out_ready = !m_tvalid || m_tready;
  assign acc0      = s0_tvalid && s0_tready;
  assign acc1      = s1_tvalid && s1_tready;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      last_served <= 1'b1;
    end else begin
      state       <= state_nxt;
      last_served <= last_served_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    last_served_nxt = last_served;
    s0_tready       = 1'b0;
    s1_tready       = 1'b0;
    grant           = 2'b00;
    case (state)
      IDLE: begin
        // last_served==1 means port 0 is next in the round-robin rotation
        if (s0_tvalid && ((STRICT_PRIO != 0) || !s1_tvalid || last_served))
          state_nxt = G0;
        else if (s1_tvalid)
          state_nxt = G1;
      end
      G0: begin
        s0_tready = out_ready;
        grant     = 2'b01;
        if (s0_tvalid && out_ready && s0_tlast) begin
          state_nxt       = IDLE;
          last_served_nxt = 1'b0;
        end
      end
      G1: begin
        s1_tready = out_ready;
        grant     = 2'b10;
        if (s1_tvalid && out_ready && s1_tlast) begin
          state_nxt       = IDLE;
          last_served_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_tdata  <= '0;
      m_tuser  <= '0;
      m_tlast  <= 1'b0;
      m_tvalid <= 1'b0;
    end else if (acc0) begin
      m_tdata  <= s0_tdata;
      m_tuser  <= s0_tuser;
      m_tlast  <= s0_tlast;
      m_tvalid <= 1'b1;
    end else if (acc1) begin
      m_tdata  <= s1_tdata;
      m_tuser  <= s1_tuser;
      m_tlast  <= s1_tlast;
      m_tvalid <= 1'b1;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

`ifdef ETH_TX_ARB_STATS_EN
  // clear wins over a coincident tlast so software sees a clean zero
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else if (clr_stats) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      if (acc0 && s0_tlast) pkt_cnt0 <= pkt_cnt0 + 32'd1;
      if (acc1 && s1_tlast) pkt_cnt1 <= pkt_cnt1 + 32'd1;
    end
  end
`endif

endmodule
